// File: rtl/fpu_issue_wb.sv
// Issue/writeback sequencer around the FPU core: accepts one request, resolves rm,
// pulses start, waits for done under a watchdog, holds the result and owns fflags.
module fpu_issue_wb #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_rm,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_rs2_lsb,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  frm,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_rs2_lsb,
  input  logic [31:0] fpu_result,
  input  logic        fpu_done,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow,
  input  logic        fpu_invalid,
  input  logic        fpu_inexact,
  input  logic        fpu_div_by_zero,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic [4:0]  wb_fflags,
  output logic        wb_illegal,
  input  logic        fflags_wr,
  input  logic [4:0]  fflags_wdata,
  output logic [4:0]  acc_fflags
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t         state, state_nx;
  logic [WDW-1:0] wdog, wdog_nx;
  logic [2:0]     rm_res;
  logic           rm_bad;
  logic           accept;
  logic           cap_done;
  logic           cap_abort;

  always_comb begin
    state_nx  = state;
    wdog_nx   = wdog;
    accept    = 1'b0;
    cap_done  = 1'b0;
    cap_abort = 1'b0;
    rm_res    = (req_rm == 3'b111) ? frm : req_rm;
    rm_bad    = (rm_res >= 3'b101);
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = rm_bad ? WB : ISSUE;
        end
      end
      ISSUE: begin
        wdog_nx = '0;
        if (fpu_done) begin
          cap_done = 1'b1;
          state_nx = WB;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        wdog_nx = wdog + 1'b1;
        if (fpu_done) begin
          cap_done = 1'b1;
          state_nx = WB;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          // the increment in this cycle is the one that reaches TIMEOUT
          cap_abort = 1'b1;
          state_nx  = WB;
        end
      end
      WB: begin
        if (wb_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nx;
      wdog  <= wdog_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpu_op      <= '0;
      fpu_rm      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_rs2_lsb <= 1'b0;
      wb_rd       <= '0;
    end else if (accept) begin
      fpu_op      <= req_op;
      fpu_rm      <= rm_res;
      fpu_a       <= req_a;
      fpu_b       <= req_b;
      fpu_rs2_lsb <= req_rs2_lsb;
      wb_rd       <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data    <= '0;
      wb_fflags  <= '0;
      wb_illegal <= 1'b0;
    end else if (accept && rm_bad) begin
      wb_data    <= '0;
      wb_fflags  <= '0;
      wb_illegal <= 1'b1;
    end else if (cap_done) begin
      wb_data    <= fpu_result;
      wb_fflags  <= {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact};
      wb_illegal <= 1'b0;
    end else if (cap_abort) begin
      wb_data    <= 32'h7FC0_0000;
      wb_fflags  <= 5'b10000;
      wb_illegal <= 1'b0;
    end
  end

  // CSR write is the younger instruction, so it overrides the retiring op's flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_fflags <= '0;
    end else if (fflags_wr) begin
      acc_fflags <= fflags_wdata;
    end else if (state == WB && wb_ready && !wb_illegal) begin
      acc_fflags <= acc_fflags | wb_fflags;
    end
  end

  assign req_ready = (state == IDLE);
  assign fpu_start = (state == ISSUE);
  assign wb_valid  = (state == WB);

endmodule

// File: tb/tb_fpu_issue_wb.sv
// Directed bench for fpu_issue_wb: vector table of single operations plus
// hand-written stall, CSR-override and mid-operation reset sequences.
module tb_fpu_issue_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [2:0]  req_rm, frm;
  logic [31:0] req_a, req_b;
  logic        req_rs2_lsb;
  logic [4:0]  req_rd;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_rs2_lsb;
  logic [31:0] fpu_result;
  logic        fpu_done;
  logic        fpu_overflow, fpu_underflow, fpu_invalid, fpu_inexact, fpu_div_by_zero;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd, wb_fflags;
  logic        wb_illegal;
  logic        fflags_wr;
  logic [4:0]  fflags_wdata;
  logic [4:0]  acc_fflags;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_issue_wb #(.TIMEOUT(63)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd), .frm(frm),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_result(fpu_result), .fpu_done(fpu_done),
    .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow), .fpu_invalid(fpu_invalid),
    .fpu_inexact(fpu_inexact), .fpu_div_by_zero(fpu_div_by_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_fflags(wb_fflags), .wb_illegal(wb_illegal),
    .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata), .acc_fflags(acc_fflags)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] NEVER = 8'hFF;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [7:0]  lat;      // cycles from start to done; NEVER = no done
    logic [31:0] res;
    logic [4:0]  flags;    // {NV,DZ,OF,UF,NX} returned by the FPU model
    logic [31:0] exp_data;
    logic [4:0]  exp_ff;
    logic        exp_ill;
    logic [2:0]  exp_rm;
    int          exp_cyc;  // cycle wb_valid first seen, accept = cycle 0
    logic [4:0]  exp_acc;  // acc_fflags after the writeback handshake
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_flags(input logic [4:0] f);
    fpu_invalid     = f[4];
    fpu_div_by_zero = f[3];
    fpu_overflow    = f[2];
    fpu_underflow   = f[1];
    fpu_inexact     = f[0];
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int c;
    int starts;
    chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = v.op; req_rm = v.rm; frm = v.frm;
    req_a = v.a; req_b = v.b; req_rd = v.rd; req_rs2_lsb = v.op[0];
    step();
    req_valid = 1'b0;
    c = 1;
    starts = 0;
    while (!wb_valid && c < 200) begin
      if (fpu_start) starts++;
      if (v.lat != NEVER && c == 1 + int'(v.lat)) begin
        fpu_done = 1'b1; fpu_result = v.res; drive_flags(v.flags);
      end else begin
        fpu_done = 1'b0; fpu_result = 32'hDEAD_BEEF; drive_flags(5'b11111);
      end
      step();
      c++;
    end
    fpu_done = 1'b0;
    chk($sformatf("v%0d wb_cycle", idx), c, v.exp_cyc);
    chk($sformatf("v%0d start_count", idx), starts, v.exp_ill ? 0 : 1);
    chk($sformatf("v%0d fpu_rm", idx), {29'd0, fpu_rm}, {29'd0, v.exp_rm});
    chk($sformatf("v%0d fpu_a", idx), fpu_a, v.a);
    chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
    chk($sformatf("v%0d wb_fflags", idx), {27'd0, wb_fflags}, {27'd0, v.exp_ff});
    chk($sformatf("v%0d wb_illegal", idx), {31'd0, wb_illegal}, {31'd0, v.exp_ill});
    chk($sformatf("v%0d wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk($sformatf("v%0d ready_after_wb", idx), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d acc_fflags", idx), {27'd0, acc_fflags}, {27'd0, v.exp_acc});
  endtask

  initial begin
    //            op    rm      frm     a             b             rd    lat    res           flags     exp_data      exp_ff    ill   exp_rm  cyc acc
    vecs[0] = '{5'd0, 3'b000, 3'b000, 32'h3F800000, 32'h40000000, 5'd1, 8'd3,  32'h40400000, 5'b00000, 32'h40400000, 5'b00000, 1'b0, 3'b000, 5,  5'b00000};
    vecs[1] = '{5'd1, 3'b111, 3'b010, 32'h11111111, 32'h22222222, 5'd2, 8'd1,  32'h12345678, 5'b00000, 32'h12345678, 5'b00000, 1'b0, 3'b010, 3,  5'b00000};
    vecs[2] = '{5'd2, 3'b111, 3'b101, 32'h33333333, 32'h44444444, 5'd3, 8'd1,  32'hAAAAAAAA, 5'b11111, 32'h00000000, 5'b00000, 1'b1, 3'b101, 1,  5'b00000};
    vecs[3] = '{5'd3, 3'b001, 3'b000, 32'h55555555, 32'h66666666, 5'd4, 8'd2,  32'h7FC00000, 5'b10001, 32'h7FC00000, 5'b10001, 1'b0, 3'b001, 4,  5'b10001};
    vecs[4] = '{5'd4, 3'b010, 3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd5, 8'd0,  32'h7F800000, 5'b00100, 32'h7F800000, 5'b00100, 1'b0, 3'b010, 2,  5'b10101};
    vecs[5] = '{5'd5, 3'b110, 3'b000, 32'h01010101, 32'h02020202, 5'd6, 8'd1,  32'hBBBBBBBB, 5'b01010, 32'h00000000, 5'b00000, 1'b1, 3'b110, 1,  5'b10101};
    vecs[6] = '{5'd6, 3'b001, 3'b011, 32'h03030303, 32'h04040404, 5'd7, NEVER, 32'h0,        5'b00000, 32'h7FC00000, 5'b10000, 1'b0, 3'b001, 65, 5'b10101};
    vecs[7] = '{5'd7, 3'b100, 3'b111, 32'h05050505, 32'h06060606, 5'd8, 8'd5,  32'h00800000, 5'b01010, 32'h00800000, 5'b01010, 1'b0, 3'b100, 7,  5'b11111};

    reset = 1'b0;
    req_valid = 1'b0; req_op = '0; req_rm = '0; frm = '0; req_a = '0; req_b = '0;
    req_rs2_lsb = 1'b0; req_rd = '0;
    fpu_result = '0; fpu_done = 1'b0; drive_flags(5'b00000);
    wb_ready = 1'b0; fflags_wr = 1'b0; fflags_wdata = '0;
    step();
    step();
    reset = 1'b1;
    step();

    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst fpu_start", {31'd0, fpu_start}, 32'd0);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst wb_illegal", {31'd0, wb_illegal}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst acc_fflags", {27'd0, acc_fflags}, 32'd0);
    chk("rst fpu_op", {27'd0, fpu_op}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Stall in WB with spurious done pulses, then CSR write in the handshake cycle.
    req_valid = 1'b1; req_op = 5'd9; req_rm = 3'b000; req_a = 32'h0F0F0F0F;
    req_b = 32'hF0F0F0F0; req_rd = 5'd9;
    step();
    req_valid = 1'b0;
    chk("stall start", {31'd0, fpu_start}, 32'd1);
    fpu_done = 1'b1; fpu_result = 32'hCAFE0001; drive_flags(5'b00100);
    step();
    chk("stall wb_valid", {31'd0, wb_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      fpu_done = k[0]; fpu_result = 32'h0BAD0000 + k; drive_flags(5'b11011);
      step();
      chk($sformatf("stall%0d wb_valid", k), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("stall%0d wb_data", k), wb_data, 32'hCAFE0001);
      chk($sformatf("stall%0d wb_fflags", k), {27'd0, wb_fflags}, 32'd4);
      chk($sformatf("stall%0d req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    fpu_done = 1'b0;
    chk("stall acc_hold", {27'd0, acc_fflags}, 32'h1F);
    wb_ready = 1'b1; fflags_wr = 1'b1; fflags_wdata = 5'b00011;
    step();
    wb_ready = 1'b0; fflags_wr = 1'b0;
    chk("csr_wins acc", {27'd0, acc_fflags}, 32'h03);
    chk("csr_wins req_ready", {31'd0, req_ready}, 32'd1);

    // Plain CSR write in IDLE.
    fflags_wr = 1'b1; fflags_wdata = 5'b01000;
    step();
    fflags_wr = 1'b0;
    chk("csr_idle acc", {27'd0, acc_fflags}, 32'h08);

    // Reset during WAIT, then a late done must be ignored.
    req_valid = 1'b1; req_op = 5'd10; req_rm = 3'b011; req_rd = 5'd10;
    step();
    req_valid = 1'b0;
    step();
    chk("mid wait req_ready", {31'd0, req_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("mid_rst acc", {27'd0, acc_fflags}, 32'd0);
    step();
    reset = 1'b1;
    fpu_done = 1'b1; fpu_result = 32'h12121212; drive_flags(5'b11111);
    step();
    fpu_done = 1'b0;
    step();
    chk("late_done wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("late_done req_ready", {31'd0, req_ready}, 32'd1);
    chk("late_done fpu_start", {31'd0, fpu_start}, 32'd0);
    chk("late_done acc", {27'd0, acc_fflags}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
